// File: rtl/reg_file_pkg.sv
// Shared definitions for the register-file scan reader slice.
//   - default data width (N) and address width (W)
//   - scan FSM state encoding
//   - count port width helper (W+1, so a full 2^W burst is representable)
package reg_file_pkg;

  localparam int unsigned RF_N_DEFAULT = 8;
  localparam int unsigned RF_W_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

  function automatic int unsigned count_width(input int unsigned w);
    return w + 1;
  endfunction

endpackage

// File: rtl/reg_file_out_stage.sv
// Single-entry valid/ready output register for the scan reader.
// Ports:
//   clk, clr     clock, asynchronous active-high clear
//   load         capture in_* this edge and present it as a valid beat
//   in_data/addr/last  beat contents to capture
//   out_ready    consumer accepts the current beat at the clk edge
//   out_valid/data/addr/last  registered beat; held stable while stalled
module reg_file_out_stage
  import reg_file_pkg::*;
#(
  parameter int unsigned N = RF_N_DEFAULT,
  parameter int unsigned W = RF_W_DEFAULT
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] in_data,
  input  logic [W-1:0] in_addr,
  input  logic         in_last,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic [W-1:0] out_addr,
  output logic         out_last
);

  // load takes priority: a capture on the same edge as an accept replaces
  // the outgoing beat, giving one beat per clock without a bubble.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_addr  <= in_addr;
      out_last  <= in_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_scan_reader.sv
// Burst reader for the register file: on start, walks count entries from
// base_addr (wrapping modulo 2^W) through the combinational read port and
// streams them out over valid/ready with a last flag.
// Ports:
//   clk, clr               clock, asynchronous active-high clear
//   start, base_addr, count  burst command (sampled only in IDLE)
//   busy, done             burst in progress / one-cycle completion pulse
//   rf_addr, rf_data       register-file read port
//   out_valid, out_ready, out_data, out_addr, out_last  output stream
//   checksum               (only with RF_SCAN_CHECKSUM_EN) XOR of accepted beats
module reg_file_scan_reader
  import reg_file_pkg::*;
#(
  parameter int unsigned N = RF_N_DEFAULT,
  parameter int unsigned W = RF_W_DEFAULT
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         start,
  input  logic [W-1:0]                 base_addr,
  input  logic [count_width(W)-1:0]    count,
  output logic                         busy,
  output logic                         done,
  output logic [W-1:0]                 rf_addr,
  input  logic [N-1:0]                 rf_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N-1:0]                 out_data,
  output logic [W-1:0]                 out_addr,
  output logic                         out_last
`ifdef RF_SCAN_CHECKSUM_EN
  ,
  output logic [N-1:0]                 checksum
`endif
);

  localparam int unsigned CW = count_width(W);

  scan_state_e   state, state_next;
  logic [W-1:0]  rf_addr_next;
  logic [CW-1:0] remaining, remaining_next;
  logic          busy_next;
  logic          load;
  logic          last_beat;

  assign last_beat = (remaining == CW'(1));

  always_comb begin
    state_next     = state;
    rf_addr_next   = rf_addr;
    remaining_next = remaining;
    busy_next      = busy;
    load           = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            rf_addr_next   = base_addr;
            remaining_next = count;
            busy_next      = 1'b1;
            state_next     = READ;
          end else begin
            state_next = DONE;
          end
        end
      end
      READ: begin
        // Capture whenever the output slot is empty or being drained.
        if (!out_valid || out_ready) begin
          load           = 1'b1;
          rf_addr_next   = rf_addr + 1'b1;
          remaining_next = remaining - 1'b1;
          if (last_beat) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      rf_addr   <= '0;
      remaining <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      rf_addr   <= rf_addr_next;
      remaining <= remaining_next;
      busy      <= busy_next;
    end
  end

  reg_file_out_stage #(
    .N(N),
    .W(W)
  ) u_out_stage (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .in_data  (rf_data),
    .in_addr  (rf_addr),
    .in_last  (last_beat),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_last (out_last)
  );

`ifdef RF_SCAN_CHECKSUM_EN
  logic start_accept;
  assign start_accept = (state == IDLE) && start;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      checksum <= '0;
    end else if (start_accept) begin
      checksum <= '0;
    end else if (out_valid && out_ready) begin
      checksum <= checksum ^ out_data;
    end
  end
`endif

endmodule

// File: tb/tb_reg_file_scan_reader.sv
module tb_reg_file_scan_reader;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [1:0] base_addr;
  logic [2:0] count;
  logic       busy;
  logic       done;
  logic [1:0] rf_addr;
  logic [7:0] rf_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_addr;
  logic       out_last;
`ifdef RF_SCAN_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  logic [7:0] mem [4];
  assign rf_data = mem[rf_addr];

  always #5 clk = ~clk;

  reg_file_scan_reader #(
    .N(8),
    .W(2)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .base_addr(base_addr),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_last (out_last)
`ifdef RF_SCAN_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  typedef struct {
    logic [1:0] base;
    logic [2:0] count;
    int         stall;
    bit         mid_start;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] addr;
    logic       last;
  } beat_t;

  vec_t       vecs[6];
  beat_t      sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_rf;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic run_burst(input vec_t v);
    int         exp_done;
    int         stalls;
    bit         seen;
    bit         got_done;
    logic [7:0] exp_sum;
    beat_t      b;
    exp_sum = '0;
    for (int i = 0; i < int'(v.count); i++) begin
      b.addr = v.base + 2'(i);
      b.data = mem[b.addr];
      b.last = (i == int'(v.count) - 1);
      sb.push_back(b);
    end
    exp_done = (v.count == 3'd0) ? 0 : int'(v.count) + 1 + v.stall;
    if (v.count != 3'd0) exp_rf = 2'(v.base + 2'(v.count));
    base_addr = v.base;
    count     = v.count;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(v.count != 3'd0));
    got_done = 0;
    stalls   = 0;
    seen     = 0;
    for (int j = 0; j < 40 && !got_done; j++) begin
      if (v.mid_start) begin
        start     = (j == 2);
        base_addr = 2'd1;
        count     = 3'd1;
      end
      if (out_valid) seen = 1;
      out_ready = !(seen && stalls < v.stall);
      if (out_valid && !out_ready) begin
        stalls++;
        if (sb.size() > 0) begin
          chk("stall_data", 32'(out_data), 32'(sb[0].data));
          chk("stall_addr", 32'(out_addr), 32'(sb[0].addr));
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("extra_beat", 32'(out_valid), 32'(0));
        end else begin
          b = sb.pop_front();
          chk("beat_data", 32'(out_data), 32'(b.data));
          chk("beat_addr", 32'(out_addr), 32'(b.addr));
          chk("beat_last", 32'(out_last), 32'(b.last));
          exp_sum ^= b.data;
        end
      end
      if (done) begin
        got_done = 1;
        chk("done_cycle", 32'(j), 32'(exp_done));
        chk("busy_at_done", 32'(busy), 32'(v.count != 3'd0));
        chk("beats_left", 32'(sb.size()), 32'(0));
        chk("rf_addr_end", 32'(rf_addr), 32'(exp_rf));
        chk("valid_at_done", 32'(out_valid), 32'(0));
`ifdef RF_SCAN_CHECKSUM_EN
        chk("checksum", 32'(checksum), 32'(exp_sum));
        if (v.base == 2'd0 && v.count == 3'd4) chk("checksum_4b", 32'(checksum), 32'h4B);
`endif
      end else begin
        @(posedge clk); #1;
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    if (!got_done) chk("done_timeout", 32'(0), 32'(1));
    sb.delete();
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'(0));
    chk("busy_after_done", 32'(busy), 32'(0));
`ifdef RF_SCAN_CHECKSUM_EN
    chk("checksum_held", 32'(checksum), 32'(exp_sum));
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats_seen;
    vec_t v;
    vecs[0] = '{base: 2'd2, count: 3'd2, stall: 0, mid_start: 0};
    vecs[1] = '{base: 2'd3, count: 3'd3, stall: 0, mid_start: 0};
    vecs[2] = '{base: 2'd2, count: 3'd2, stall: 3, mid_start: 0};
    vecs[3] = '{base: 2'd0, count: 3'd0, stall: 0, mid_start: 0};
    vecs[4] = '{base: 2'd0, count: 3'd4, stall: 0, mid_start: 1};
    vecs[5] = '{base: 2'd1, count: 3'd4, stall: 2, mid_start: 0};

    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'hBB; mem[3] = 8'hF0;
    clr = 1'b1; start = 1'b0; base_addr = 2'd2; count = 3'd2; out_ready = 1'b1;
    exp_rf = 2'd0;

    // Held in reset for 100ns with start pulsed: nothing may move.
    for (int i = 0; i < 10; i++) begin
      start = (i % 2 == 0);
      @(posedge clk); #1;
      if (i % 3 == 0) begin
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_rf_addr", 32'(rf_addr), 32'(0));
      end
    end
    start = 1'b0;
    clr   = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_rst", 32'(busy | done | out_valid), 32'(0));

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      run_burst(v);
    end

    // clr in the middle of a clock period while beat 2 is presented.
    base_addr = 2'd0; count = 3'd4; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    beats_seen = 0;
    for (int j = 0; j < 10 && beats_seen < 2; j++) begin
      if (out_valid) beats_seen++;
      if (beats_seen < 2) begin
        @(posedge clk); #1;
      end
    end
    chk("beat2_reached", 32'(beats_seen), 32'(2));
    #2;
    clr = 1'b1;
    #1;
    chk("async_clr_valid", 32'(out_valid), 32'(0));
    chk("async_clr_busy", 32'(busy), 32'(0));
    chk("async_clr_rf_addr", 32'(rf_addr), 32'(0));
    chk("async_clr_data", 32'(out_data), 32'(0));
    @(posedge clk); #1;
    clr = 1'b0;
    exp_rf = 2'd0;
    @(posedge clk); #1;
    v = '{base: 2'd2, count: 3'd1, stall: 0, mid_start: 0};
    run_burst(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
